smac_simd_acc: RTL and testbench

- Parametrised successor of the sub-MAC unit: a SIMD multiply-accumulate engine for the DTPU datapath.
- Precision is runtime-selectable. DATA_W is split into 8-, 16- or 32-bit signed lanes.
- Each lane accumulates products over a programmable window of beats. The window closes with saturated per-lane results, or with a single chained (dot-product) sum.
- Valid/ready handshakes on both sides replace the bare CE gating of the previous generation, so the block can sit between the weight/activation FIFOs and the result writer.

---
 rtl/smac_simd_acc.sv | 231 +++++++++++++++++++++++
 tb/tb_smac_simd_acc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smac_simd_acc.sv
`default_nettype none
// ============================================================================
//  Module      : smac_simd_acc
//  Description : SIMD signed multiply-accumulate over a programmable beat
//                window; 8/16/32-bit lanes, per-lane or chained saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module smac_simd_acc #(
    parameter int DATA_W = 64,
    parameter int GUARD  = 8,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                sclr_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   data_input,
    input  logic [DATA_W-1:0]   weight,
    input  logic [1:0]          select_precision,
    input  logic                active_chain,
    input  logic [LEN_W-1:0]    acc_len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   res_mac_n,
    output logic [DATA_W/8-1:0] sat_flag,
    output logic                cfg_err
);

    localparam int c_NB = DATA_W / 8;
    // Wide enough for every mode's chained sum and for the 32-bit saturation bounds.
    localparam int c_CW = 64 + GUARD + $clog2(DATA_W / 32);
    localparam logic signed [c_CW-1:0] c_CMAX = c_CW'(longint'(32'h7FFF_FFFF));
    localparam logic signed [c_CW-1:0] c_CMIN = c_CW'(-longint'(32'h8000_0000));

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACC   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]        r_state, w_state_nxt;
    logic              w_accept, w_first, w_last;
    logic [LEN_W-1:0]  r_cnt, r_len;
    logic [1:0]        r_prec;
    logic              r_chain, r_cfg_err;

    logic              r_s1_vld, r_s1_first, r_s1_last;
    logic [DATA_W-1:0] r_s1_d, r_s1_w;
    logic              r_s2_vld, r_s2_first, r_s2_last;
    logic              r_s3_done, r_s4_done, r_out_vld;
    logic [DATA_W-1:0] r_res;
    logic [c_NB-1:0]   r_sat;

    assign in_ready  = sclr_n & (r_state != c_ST_DRAIN);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_vld;
    assign res_mac_n = r_res;
    assign sat_flag  = r_sat;
    assign cfg_err   = r_cfg_err;

    always_comb begin
        w_state_nxt = r_state;
        w_first     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_first = w_accept;
                w_last  = w_accept & (acc_len == '0);
                if (w_accept) w_state_nxt = (acc_len == '0) ? c_ST_DRAIN : c_ST_ACC;
            end
            c_ST_ACC: begin
                w_last = w_accept & (r_cnt == r_len);
                if (w_last) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (r_out_vld && out_ready) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_prec    <= '0;
            r_chain   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_first) begin
                r_cnt   <= LEN_W'(1);
                r_len   <= acc_len;
                r_prec  <= select_precision;
                r_chain <= active_chain;
                if (select_precision == 2'd3) r_cfg_err <= 1'b1;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

    logic [DATA_W-1:0]      w_lane_res [3];
    logic [c_NB-1:0]        w_lane_sat [3];
    logic signed [c_CW-1:0] w_sum      [3];

    // Every lane width is computed in parallel; the window's latched precision picks one at the end.
    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int c_W = 8 << m;
        localparam int c_L = DATA_W / c_W;
        localparam int c_P = 2 * c_W;
        localparam int c_A = c_P + GUARD;
        localparam int c_B = c_W / 8;
        localparam logic signed [c_A-1:0] c_MAX = c_A'((longint'(1) <<< (c_W - 1)) - longint'(1));
        localparam logic signed [c_A-1:0] c_MIN = c_A'(-(longint'(1) <<< (c_W - 1)));

        logic [DATA_W-1:0]      w_res;
        logic [c_NB-1:0]        w_sat;
        logic signed [c_CW-1:0] w_ext [c_L];
        logic signed [c_CW-1:0] w_tot;

        for (genvar k = 0; k < c_L; k++) begin : g_lane
            logic signed [c_W-1:0] w_a, w_b;
            logic signed [c_P-1:0] r_prod;
            logic signed [c_A-1:0] r_acc;
            logic                  w_hi, w_lo;

            assign w_a = r_s1_d[k*c_W +: c_W];
            assign w_b = r_s1_w[k*c_W +: c_W];

            always_ff @(posedge clk) begin
                if (!sclr_n) begin
                    r_prod <= '0;
                    r_acc  <= '0;
                end else begin
                    r_prod <= c_P'(w_a) * c_P'(w_b);
                    if (r_s2_vld) r_acc <= r_s2_first ? c_A'(r_prod) : r_acc + c_A'(r_prod);
                end
            end

            assign w_hi = (r_acc > c_MAX);
            assign w_lo = (r_acc < c_MIN);
            assign w_res[k*c_W +: c_W] = w_hi ? c_MAX[c_W-1:0] :
                                         (w_lo ? c_MIN[c_W-1:0] : r_acc[c_W-1:0]);
            assign w_sat[k*c_B +: c_B] = {c_B{w_hi | w_lo}};
            assign w_ext[k] = c_CW'(r_acc);
        end

        always_comb begin
            w_tot = '0;
            for (int k = 0; k < c_L; k++) w_tot = w_tot + w_ext[k];
        end

        assign w_lane_res[m] = w_res;
        assign w_lane_sat[m] = w_sat;
        assign w_sum[m]      = w_tot;
    end

    logic [DATA_W-1:0]      w_sel_res;
    logic [c_NB-1:0]        w_sel_sat;
    logic signed [c_CW-1:0] w_sel_sum;
    logic                   w_chain_hi, w_chain_lo;
    logic [31:0]            w_chain_val;

    always_comb begin
        w_sel_res = w_lane_res[0];
        w_sel_sat = w_lane_sat[0];
        w_sel_sum = w_sum[0];
        case (r_prec)
            2'd1: begin
                w_sel_res = w_lane_res[1];
                w_sel_sat = w_lane_sat[1];
                w_sel_sum = w_sum[1];
            end
            2'd2: begin
                w_sel_res = w_lane_res[2];
                w_sel_sat = w_lane_sat[2];
                w_sel_sum = w_sum[2];
            end
            default: ;
        endcase
        w_chain_hi  = (w_sel_sum > c_CMAX);
        w_chain_lo  = (w_sel_sum < c_CMIN);
        w_chain_val = w_chain_hi ? 32'h7FFF_FFFF :
                      (w_chain_lo ? 32'h8000_0000 : w_sel_sum[31:0]);
    end

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_d     <= '0;
            r_s1_w     <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s3_done  <= 1'b0;
            r_s4_done  <= 1'b0;
            r_out_vld  <= 1'b0;
            r_res      <= '0;
            r_sat      <= '0;
        end else begin
            r_s1_vld   <= w_accept;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            if (w_accept) begin
                r_s1_d <= data_input;
                r_s1_w <= weight;
            end
            r_s2_vld   <= r_s1_vld;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s3_done  <= r_s2_vld & r_s2_last;
            r_s4_done  <= r_s3_done;
            if (r_s4_done)      r_out_vld <= 1'b1;
            else if (out_ready) r_out_vld <= 1'b0;
            // Result loads once the last beat has been accumulated, then holds.
            if (r_s3_done) begin
                if (r_chain) begin
                    r_res <= DATA_W'(w_chain_val);
                    r_sat <= c_NB'(w_chain_hi | w_chain_lo);
                end else begin
                    r_res <= w_sel_res;
                    r_sat <= w_sel_sat;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smac_simd_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smac_simd_acc
//  Description : Self-checking bench for smac_simd_acc against an arithmetic
//                reference model of windowed lane/chain MAC results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smac_simd_acc;

    localparam int c_DW = 64;
    localparam int c_LW = 8;

    logic              clk = 1'b0;
    logic              sclr_n;
    logic              in_valid;
    logic              in_ready;
    logic [c_DW-1:0]   data_input;
    logic [c_DW-1:0]   weight;
    logic [1:0]        select_precision;
    logic              active_chain;
    logic [c_LW-1:0]   acc_len;
    logic              out_valid;
    logic              out_ready;
    logic [c_DW-1:0]   res_mac_n;
    logic [c_DW/8-1:0] sat_flag;
    logic              cfg_err;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] tb_d [0:255];
    logic [63:0] tb_w [0:255];

    smac_simd_acc #(.DATA_W(c_DW), .GUARD(8), .LEN_W(c_LW)) u_dut (
        .clk              (clk),
        .sclr_n           (sclr_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .data_input       (data_input),
        .weight           (weight),
        .select_precision (select_precision),
        .active_chain     (active_chain),
        .acc_len          (acc_len),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .res_mac_n        (res_mac_n),
        .sat_flag         (sat_flag),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [127:0] lane_val(input logic [63:0] x, input int k, input int w);
        logic [63:0] u;
        u = (x >> (k * w)) & ((64'd1 << w) - 64'd1);
        if (u[w-1]) return $signed({64'd0, u}) - (128'sd1 <<< w);
        return $signed({64'd0, u});
    endfunction

    // Exact sums of products per lane, then saturation of the plain integer totals.
    task automatic model(input logic [1:0] prec, input logic chain, input int nb,
                         output logic [63:0] res, output logic [7:0] sat);
        int w, nl;
        logic signed [127:0] acc, tot, mx, mn, v;
        logic [127:0] msk;
        w  = (prec == 2'd1) ? 16 : ((prec == 2'd2) ? 32 : 8);
        nl = 64 / w;
        res = '0;
        sat = '0;
        tot = '0;
        for (int k = 0; k < nl; k++) begin
            acc = '0;
            for (int b = 0; b < nb; b++) acc = acc + lane_val(tb_d[b], k, w) * lane_val(tb_w[b], k, w);
            tot = tot + acc;
            mx = (128'sd1 <<< (w - 1)) - 128'sd1;
            mn = -mx - 128'sd1;
            v = acc;
            if (acc > mx) v = mx;
            else if (acc < mn) v = mn;
            if (v != acc) for (int j = 0; j < w / 8; j++) sat[k*(w/8)+j] = 1'b1;
            msk = (128'd1 << w) - 128'd1;
            res = res | 64'((v & msk) << (k * w));
        end
        if (chain) begin
            mx = 128'sd2147483647;
            mn = -128'sd2147483648;
            v = tot;
            if (tot > mx) v = mx;
            else if (tot < mn) v = mn;
            res = 64'(v & 128'hFFFF_FFFF);
            sat = {7'd0, (v != tot)};
        end
    endtask

    task automatic send_window(input logic [1:0] prec, input logic chain, input int len,
                               input int nbub, input bit mutate);
        int  sent, bub, cyc;
        bit  acc;
        sent = 0;
        bub  = nbub;
        cyc  = 0;
        while (sent <= len && cyc < 400) begin
            if (bub > 0 && sent > 0 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                bub--;
            end else begin
                in_valid   = 1'b1;
                data_input = tb_d[sent];
                weight     = tb_w[sent];
                if (sent == 0 || !mutate) begin
                    select_precision = prec;
                    active_chain     = chain;
                    acc_len          = c_LW'(len);
                end else begin
                    select_precision = (sent == 1) ? 2'd2 : 2'($urandom_range(0, 3));
                    active_chain     = 1'($urandom_range(0, 1));
                    acc_len          = c_LW'($urandom);
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        if (sent <= len) check("send_timeout", 128'(sent), 128'(len + 1));
    endtask

    task automatic run_case(input string tag, input logic [1:0] prec, input logic chain, input int len,
                            input int nbub, input bit mutate, input int rdly, input bit hold);
        logic [63:0] er;
        logic [7:0]  es;
        int          lat;
        model(prec, chain, len + 1, er, es);
        out_ready = (rdly == 0);
        send_window(prec, chain, len, nbub, mutate);
        in_valid = hold;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(4));
        check({tag, "_res"}, 128'(res_mac_n), 128'(er));
        check({tag, "_sat"}, 128'(sat_flag), 128'(es));
        for (int i = 0; i < rdly; i++) begin
            check({tag, "_bp_rdy"}, 128'(in_ready), 128'(0));
            check({tag, "_bp_vld"}, 128'(out_valid), 128'(1));
            check({tag, "_bp_res"}, 128'({sat_flag, res_mac_n}), 128'({es, er}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_done_vld"}, 128'(out_valid), 128'(0));
        check({tag, "_done_rdy"}, 128'(in_ready), 128'(1));
        check({tag, "_keep"}, 128'({sat_flag, res_mac_n}), 128'({es, er}));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            tb_d[i] = {$urandom, $urandom};
            tb_w[i] = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                tb_d[i] = tb_d[i] & 64'h0F0F_0F0F_0F0F_0F0F;
                tb_w[i] = tb_w[i] & 64'h8707_8707_8707_8707;
            end
        end
    endtask

    initial begin
        int  got, cyc, seen;
        bit  acc;
        sclr_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data_input = '0;
        weight = '0;
        select_precision = '0;
        active_chain = 1'b0;
        acc_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_res", 128'(res_mac_n), 128'(0));
        check("rst_sat", 128'(sat_flag), 128'(0));
        check("rst_cfg_err", 128'(cfg_err), 128'(0));
        sclr_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            tb_d[i] = 64'h0303_0303_0303_0303;
            tb_w[i] = 64'h0202_0202_0202_0202;
        end
        run_case("basic8", 2'd0, 1'b0, 3, 0, 1'b0, 0, 1'b0);
        check("basic8_const", 128'(res_mac_n), 128'(64'h1818_1818_1818_1818));

        for (int i = 0; i < 2; i++) begin
            tb_d[i] = 64'h0000_0000_8000_7FFF;
            tb_w[i] = 64'h0000_0000_7FFF_7FFF;
        end
        run_case("sat16", 2'd1, 1'b0, 1, 0, 1'b0, 0, 1'b0);
        check("sat16_const", 128'({sat_flag, res_mac_n}), 128'({8'h0F, 64'h0000_0000_8000_7FFF}));

        tb_d[0] = 64'hFFFF_FFFE_0000_0005;
        tb_w[0] = 64'h0000_0003_0000_0007;
        run_case("chain32", 2'd2, 1'b1, 0, 0, 1'b0, 0, 1'b0);
        check("chain32_const", 128'({sat_flag, res_mac_n}), 128'({8'h00, 64'h0000_0000_0000_001D}));

        fill_random(8);
        run_case("backpr", 2'd0, 1'b0, 4, 0, 1'b0, 10, 1'b1);

        fill_random(8);
        run_case("clean8", 2'd0, 1'b0, 5, 0, 1'b0, 0, 1'b0);
        run_case("bubble8", 2'd0, 1'b0, 5, 3, 1'b1, 0, 1'b0);
        check("bubble8_cfg_err", 128'(cfg_err), 128'(0));

        // Abort a window after two accepted beats.
        fill_random(8);
        select_precision = 2'd0;
        active_chain = 1'b0;
        acc_len = c_LW'(5);
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 2 && cyc < 50) begin
            in_valid = 1'b1;
            data_input = tb_d[got];
            weight = tb_w[got];
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) got++;
            cyc++;
        end
        in_valid = 1'b0;
        sclr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sclr_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_valid", 128'(seen), 128'(0));
        out_ready = 1'b0;
        fill_random(8);
        run_case("midrst_next", 2'd0, 1'b0, 2, 0, 1'b0, 0, 1'b0);

        fill_random(8);
        run_case("resv", 2'd3, 1'b0, 2, 0, 1'b0, 0, 1'b0);
        check("resv_cfg_err", 128'(cfg_err), 128'(1));
        fill_random(8);
        run_case("resv_next", 2'd1, 1'b0, 1, 0, 1'b0, 0, 1'b0);
        check("resv_sticky", 128'(cfg_err), 128'(1));
        sclr_n = 1'b0;
        @(posedge clk); #1;
        check("resv_cleared", 128'(cfg_err), 128'(0));
        sclr_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 14; t++) begin
            fill_random(8);
            run_case($sformatf("rnd%0d", t), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
